// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master: controller side (drives strobes/selects, reads Op/Func/Zero).
// slave : datapath side.
interface multicycle_controller_if;
    logic [3:0] Op;
    logic [8:0] Func;
    logic       Zero;

    logic       AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite;
    logic       OldPCWrite, MDRWrite, ResultSrc, AWrite, BWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       halted;

    modport master (
        input  Op, Func, Zero,
        output AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite,
               OldPCWrite, MDRWrite, ResultSrc, AWrite, BWrite,
               ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl, state, halted
    );

    modport slave (
        output Op, Func, Zero,
        input  AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite,
               OldPCWrite, MDRWrite, ResultSrc, AWrite, BWrite,
               ALUSrcA, ALUSrcB, ImmSrc, PCSrc, ALUControl, state, halted
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a 16-bit multicycle CPU.
// Optional feature macro: ILLEGAL_TRAP_EN -- illegal Op/Func in DECODE traps
// into HALT (code 15) until reset; otherwise illegal encodings act as a
// 2-cycle NOP and halted is tied low.
// Outputs are decoded from the current state and forced to 0 while reset is
// high, so FETCH strobes appear in the very first cycle after reset release.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMRD  = 4'd2,
        S_LDWB   = 4'd3,
        S_MEMWR  = 4'd4,
        S_JMP    = 4'd5,
        S_BRZ    = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_HALT   = 4'd15
    } state_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t S_ILLEGAL = S_HALT;
`else
    localparam state_t S_ILLEGAL = S_FETCH;
`endif

    state_t     st;
    logic [2:0] alu_q;     // ALU operation latched in DECODE
    logic       moveto_q;  // MOVETO writes Ri instead of R0

    logic [2:0] f_alu;
    logic       f_legal, f_nop, f_moveto;

    // Decode the one-hot CTYPE function field; anything not exactly one
    // defined bit is illegal.
    always_comb begin
        f_alu    = 3'b000;
        f_legal  = 1'b1;
        f_nop    = 1'b0;
        f_moveto = 1'b0;
        case (bus.Func)
            9'h100:  begin f_alu = 3'b101; f_moveto = 1'b1; end
            9'h080:  f_alu = 3'b110;
            9'h040:  f_alu = 3'b000;
            9'h020:  f_alu = 3'b001;
            9'h010:  f_alu = 3'b010;
            9'h008:  f_alu = 3'b011;
            9'h004:  f_alu = 3'b100;
            9'h002:  f_nop = 1'b1;
            default: f_legal = 1'b0;
        endcase
    end

    // State register; Op/Func are only looked at in DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= S_FETCH;
            alu_q    <= 3'b000;
            moveto_q <= 1'b0;
        end else begin
            case (st)
                S_FETCH:  st <= S_DECODE;
                S_DECODE: begin
                    case (bus.Op)
                        4'b0000: st <= S_MEMRD;
                        4'b0001: st <= S_MEMWR;
                        4'b0010: st <= S_JMP;
                        4'b0100: st <= S_BRZ;
                        4'b1000: begin
                            if (f_nop)
                                st <= S_FETCH;
                            else if (f_legal) begin
                                st       <= S_EXECR;
                                alu_q    <= f_alu;
                                moveto_q <= f_moveto;
                            end else
                                st <= S_ILLEGAL;
                        end
                        4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                            st       <= S_EXECI;
                            alu_q    <= {1'b0, bus.Op[1:0]};
                            moveto_q <= 1'b0;
                        end
                        default: st <= S_ILLEGAL;
                    endcase
                end
                S_MEMRD:          st <= S_LDWB;
                S_EXECR, S_EXECI: st <= S_ALUWB;
                S_HALT:           st <= S_HALT;
                default:          st <= S_FETCH;
            endcase
        end
    end

    // Moore output decode, gated off during reset.
    always_comb begin
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.A3Src      = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.OldPCWrite = 1'b0;
        bus.MDRWrite   = 1'b0;
        bus.ResultSrc  = 1'b0;
        bus.AWrite     = 1'b0;
        bus.BWrite     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.PCSrc      = 2'b00;
        bus.ALUControl = 3'b000;
        if (!reset) begin
            case (st)
                S_FETCH: begin
                    bus.IRWrite    = 1'b1;
                    bus.OldPCWrite = 1'b1;
                    bus.ALUSrcB    = 2'b01;
                    bus.PCWrite    = 1'b1;
                end
                S_DECODE: begin
                    bus.AWrite = 1'b1;
                    bus.BWrite = 1'b1;
                end
                S_MEMRD: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MDRWrite = 1'b1;
                end
                S_LDWB: begin
                    bus.ResultSrc = 1'b1;
                    bus.RegWrite  = 1'b1;
                end
                S_MEMWR: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                S_JMP: begin
                    bus.PCSrc   = 2'b01;
                    bus.PCWrite = 1'b1;
                end
                S_BRZ: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = 3'b101;
                    bus.PCSrc      = 2'b10;
                    bus.PCWrite    = bus.Zero;
                end
                S_EXECR: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUControl = alu_q;
                end
                S_EXECI: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUSrcB    = 2'b10;
                    bus.ALUControl = alu_q;
                end
                S_ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.A3Src    = moveto_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = st;
`ifdef ILLEGAL_TRAP_EN
    assign bus.halted = (st == S_HALT) && !reset;
`else
    assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Expectations follow the ILLEGAL_TRAP_EN build setting.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {AdrSrc,MemWrite,IRWrite,RegWrite,A3Src,PCWrite,OldPCWrite,MDRWrite,ResultSrc,AWrite,BWrite}
    function automatic logic [10:0] strb();
        return {bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.A3Src,
                bus.PCWrite, bus.OldPCWrite, bus.MDRWrite, bus.ResultSrc,
                bus.AWrite, bus.BWrite};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check state code and the full strobe vector together.
    task automatic chk_st(input string tag, input logic [3:0] s, input logic [10:0] sb);
        chk({tag, ".state"}, {12'd0, bus.state}, {12'd0, s});
        chk({tag, ".strobes"}, {5'd0, strb()}, {5'd0, sb});
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    localparam logic [10:0] SB_FETCH = 11'h130;
    localparam logic [10:0] SB_DEC   = 11'h003;

    initial begin
        reset    = 1'b1;
        bus.Op   = 4'b0000;
        bus.Func = 9'h000;
        bus.Zero = 1'b0;

        // Reset held for two cycles
        cyc();
        chk_st("rst1", 4'd0, 11'h000);
        chk("rst1.halted", {15'd0, bus.halted}, 16'd0);
        cyc();
        chk_st("rst2", 4'd0, 11'h000);
        chk("rst2.alu", {13'd0, bus.ALUControl, 2'b00} | {14'd0, bus.ALUSrcB}, 16'd0);

        // First cycle after release is FETCH
        reset = 1'b0;
        #1;
        chk_st("fetch0", 4'd0, SB_FETCH);
        chk("fetch0.srcb", {14'd0, bus.ALUSrcB}, 16'd1);

        // LOAD: 0,1,2,3,0 ; Op change in MEMRD must be ignored
        cyc(); chk_st("ld.dec", 4'd1, SB_DEC);
        cyc(); chk_st("ld.memrd", 4'd2, 11'h408);
        bus.Op = 4'b0011;
        cyc(); chk_st("ld.wb", 4'd3, 11'h084);
        cyc(); chk_st("ld.end", 4'd0, SB_FETCH);

        // STORE
        bus.Op = 4'b0001;
        cyc(); chk_st("st.dec", 4'd1, SB_DEC);
        cyc(); chk_st("st.memwr", 4'd4, 11'h600);
        cyc(); chk_st("st.end", 4'd0, SB_FETCH);

        // JUMP
        bus.Op = 4'b0010;
        cyc(); chk_st("jmp.dec", 4'd1, SB_DEC);
        cyc(); chk_st("jmp.exe", 4'd5, 11'h020);
        chk("jmp.pcsrc", {14'd0, bus.PCSrc}, 16'd1);
        cyc(); chk_st("jmp.end", 4'd0, SB_FETCH);

        // BRZ taken
        bus.Op = 4'b0100; bus.Zero = 1'b1;
        cyc(); chk_st("brz1.dec", 4'd1, SB_DEC);
        cyc(); chk_st("brz1.exe", 4'd6, 11'h020);
        chk("brz1.pcsrc", {14'd0, bus.PCSrc}, 16'd2);
        chk("brz1.alu", {13'd0, bus.ALUControl}, 16'd5);
        chk("brz1.srca", {14'd0, bus.ALUSrcA}, 16'd2);
        cyc(); chk_st("brz1.end", 4'd0, SB_FETCH);

        // BRZ not taken
        bus.Zero = 1'b0;
        cyc(); chk_st("brz0.dec", 4'd1, SB_DEC);
        cyc(); chk_st("brz0.exe", 4'd6, 11'h000);
        cyc(); chk_st("brz0.end", 4'd0, SB_FETCH);

        // CTYPE MOVETO; Func changed in EXECR must not disturb the latched kind
        bus.Op = 4'b1000; bus.Func = 9'h100;
        cyc(); chk_st("mvto.dec", 4'd1, SB_DEC);
        cyc(); chk_st("mvto.exe", 4'd7, 11'h000);
        bus.Func = 9'h020;
        #1;
        chk("mvto.alu", {13'd0, bus.ALUControl}, 16'd5);
        chk("mvto.srcb", {14'd0, bus.ALUSrcB}, 16'd0);
        cyc(); chk_st("mvto.wb", 4'd9, 11'h0C0);
        cyc(); chk_st("mvto.end", 4'd0, SB_FETCH);

        // CTYPE SUB
        cyc(); chk_st("sub.dec", 4'd1, SB_DEC);
        cyc(); chk_st("sub.exe", 4'd7, 11'h000);
        chk("sub.alu", {13'd0, bus.ALUControl}, 16'd1);
        cyc(); chk_st("sub.wb", 4'd9, 11'h080);
        cyc(); chk_st("sub.end", 4'd0, SB_FETCH);

        // CTYPE NOT then NOP (2 cycles)
        bus.Func = 9'h004;
        cyc(); cyc(); chk("not.alu", {13'd0, bus.ALUControl}, 16'd4);
        cyc(); cyc(); chk_st("not.end", 4'd0, SB_FETCH);
        bus.Func = 9'h002;
        cyc(); chk_st("nop.dec", 4'd1, SB_DEC);
        cyc(); chk_st("nop.end", 4'd0, SB_FETCH);

        // SUBI
        bus.Op = 4'b1101;
        cyc(); chk_st("subi.dec", 4'd1, SB_DEC);
        cyc(); chk_st("subi.exe", 4'd8, 11'h000);
        chk("subi.srcb", {14'd0, bus.ALUSrcB}, 16'd2);
        chk("subi.alu", {13'd0, bus.ALUControl}, 16'd1);
        chk("subi.imm", {14'd0, bus.ImmSrc}, 16'd0);
        cyc(); chk_st("subi.wb", 4'd9, 11'h080);
        cyc(); chk_st("subi.end", 4'd0, SB_FETCH);

        // ORI
        bus.Op = 4'b1111;
        cyc(); cyc(); chk_st("ori.exe", 4'd8, 11'h000);
        chk("ori.alu", {13'd0, bus.ALUControl}, 16'd3);
        cyc(); cyc(); chk_st("ori.end", 4'd0, SB_FETCH);

        // Illegal Func (two bits set)
        bus.Op = 4'b1000; bus.Func = 9'h060;
        cyc(); chk_st("ilf.dec", 4'd1, SB_DEC);
        cyc();
`ifdef ILLEGAL_TRAP_EN
        chk_st("ilf.halt", 4'd15, 11'h000);
        chk("ilf.halted", {15'd0, bus.halted}, 16'd1);
        bus.Op = 4'b0000; bus.Func = 9'h000;
        cyc(); chk_st("ilf.hold", 4'd15, 11'h000);
        chk("ilf.hold.halted", {15'd0, bus.halted}, 16'd1);
        reset = 1'b1;
        #1;
        chk("ilf.rst.halted", {15'd0, bus.halted}, 16'd0);
        chk("ilf.rst.strobes", {5'd0, strb()}, 16'd0);
        cyc();
        reset = 1'b0;
        #1;
`else
        chk("ilf.halted", {15'd0, bus.halted}, 16'd0);
`endif
        chk_st("ilf.fetch", 4'd0, SB_FETCH);

        // Illegal Op
        bus.Op = 4'b0011;
        cyc(); chk_st("ilo.dec", 4'd1, SB_DEC);
        cyc();
`ifdef ILLEGAL_TRAP_EN
        chk_st("ilo.halt", 4'd15, 11'h000);
        chk("ilo.halted", {15'd0, bus.halted}, 16'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
`else
        chk("ilo.halted", {15'd0, bus.halted}, 16'd0);
`endif
        chk_st("ilo.fetch", 4'd0, SB_FETCH);

        // Reset mid-LOAD in MEMRD kills the MDR strobe, then refetch
        bus.Op = 4'b0000;
        cyc(); cyc(); chk_st("ab.memrd", 4'd2, 11'h408);
        reset = 1'b1;
        #1;
        chk("ab.strobes", {5'd0, strb()}, 16'd0);
        cyc(); chk_st("ab.rst", 4'd0, 11'h000);
        reset = 1'b0;
        #1;
        chk_st("ab.fetch", 4'd0, SB_FETCH);
        cyc(); chk_st("ab.dec", 4'd1, SB_DEC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs Op [3:0] (Instr[15:12]), Func [8:0] (Instr[8:0]) and Zero [0:0] (ALU zero flag), all from the datapath.
REQ-004 SHALL have 1-bit outputs AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite, OldPCWrite, MDRWrite, ResultSrc, AWrite and BWrite.
REQ-005 SHALL have 2-bit outputs ALUSrcA, ALUSrcB, ImmSrc and PCSrc, and 3-bit output ALUControl.
REQ-006 SHALL have output state [3:0] (current state code) and output halted [0:0].

Function
REQ-007 SHALL be a Moore FSM: registered state, outputs decoded from state (plus Zero in BRZ only); any output not listed for a state is 0.
REQ-008 ALUControl encoding SHALL be 000 add, 001 sub, 010 and, 011 or, 100 not A, 101 pass A, 110 pass B.
REQ-009 Opcodes SHALL be 0000 LOAD, 0001 STORE, 0010 JUMP, 0100 BRZ, 1000 CTYPE, 1100 ADDI, 1101 SUBI, 1110 ANDI, 1111 ORI; all other values are illegal.
REQ-010 CTYPE Func SHALL be one-hot: [8] MOVETO (Ri<=R0), [7] MOVEFROM (R0<=Ri), [6] ADD, [5] SUB, [4] AND, [3] OR, [2] NOT, [1] NOP. Zero or multiple bits set is illegal.
REQ-011 FETCH (code 0): AdrSrc=0, IRWrite=1, OldPCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUControl=000, PCSrc=00, PCWrite=1. Next state: DECODE.
REQ-012 DECODE (1): AWrite=1, BWrite=1. Next state by Op: LOAD->MEMRD, STORE->MEMWR, JUMP->JMP, BRZ->BRZ, CTYPE->EXECR (NOP->FETCH), ADDI..ORI->EXECI, illegal->REQ-021.
REQ-013 MEMRD (2): AdrSrc=1, MDRWrite=1 -> LDWB (3).
REQ-014 LDWB (3): ResultSrc=1, RegWrite=1, A3Src=0 (R0) -> FETCH.
REQ-015 MEMWR (4): AdrSrc=1, MemWrite=1 -> FETCH.
REQ-016 JMP (5): PCSrc=01, PCWrite=1 -> FETCH.
REQ-017 BRZ (6): ALUSrcA=10, ALUControl=101, PCSrc=10, and PCWrite=Zero in the same cycle -> FETCH.
REQ-018 EXECR (7): ALUSrcA=10, ALUSrcB=00, ALUControl from Func (MOVETO 101, MOVEFROM 110, ADD 000, SUB 001, AND 010, OR 011, NOT 100) -> ALUWB. The CTYPE kind SHALL be latched in DECODE.
REQ-019 EXECI (8): ALUSrcA=10, ALUSrcB=10, ImmSrc=00, ALUControl 000/001/010/011 for ADDI/SUBI/ANDI/ORI -> ALUWB.
REQ-020 ALUWB (9): ResultSrc=0, RegWrite=1, A3Src=1 if MOVETO else 0 -> FETCH.
REQ-021 Cycle counts SHALL be: LOAD 4, STORE 3, JUMP 3, BRZ 3, CTYPE ALU/MOVE 4, NOP 2, I-type 4.
REQ-022 Op and Func SHALL be sampled only in DECODE; changes in other states are ignored.

Reset
REQ-023 While reset=1, all control outputs SHALL be 0 and halted=0; at the clk edge with reset=1, state<=FETCH (0).
REQ-024 Reset asserted in any state, including HALT, SHALL abort the instruction with no write strobe in that cycle; FETCH is entered the cycle after reset deasserts.

Configuration
REQ-025 Macro ILLEGAL_TRAP_EN: when defined, an illegal Op or Func in DECODE SHALL go to HALT (code 15); HALT holds all strobes at 0 and halted=1 until reset.
REQ-026 Without ILLEGAL_TRAP_EN, illegal encodings SHALL return to FETCH as a 2-cycle NOP, HALT is unreachable, and halted is tied to 0.

Verification
REQ-027 Reset for 2 cycles, then release -> state=0, IRWrite=PCWrite=OldPCWrite=1 on the first cycle; all strobes 0 during reset.
REQ-028 Op=0000 -> states 0,1,2,3,0; MDRWrite=1 in state 2; RegWrite=1, ResultSrc=1, A3Src=0 in state 3.
REQ-029 Op=0100 with Zero=1 -> PCWrite=1, PCSrc=10 in state 6; repeat with Zero=0 -> PCWrite=0; both return to state 0.
REQ-030 Op=1000, Func=9'h100 (MOVETO) -> ALUControl=101 in state 7, A3Src=1 in state 9; Func=9'h020 (SUB) -> ALUControl=001, A3Src=0.
REQ-031 Op=1101 -> state 8 with ALUSrcB=10, ALUControl=001, then state 9 with RegWrite=1.
REQ-032 Op=0011 or Func=9'h060: with ILLEGAL_TRAP_EN -> state 15, halted=1, held until reset; without it -> state 0 after DECODE, halted=0.
